reset_sequencer: RTL

//   Conditions the asynchronous board reset. Assertion is asynchronous; deassertion is synchronous.

---
 rtl/reset_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Board reset conditioner: async-assert / sync-deassert of rst, then staggered release of
// CHANNELS reset outputs GAP cycles apart, plus a soft-reset pulse. Define RESET_SEQ_ACK_EN for ack gating.
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int CHANNELS    = 3,
  parameter int GAP         = 16,
  parameter int MIN_PULSE   = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready
`ifdef RESET_SEQ_ACK_EN
  ,
  input  logic [CHANNELS-1:0] ack,
  output logic                ack_err
`endif
);

  localparam int CNT_TOP = (GAP > MIN_PULSE) ? GAP : MIN_PULSE;
  localparam int CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {S_HOLD, S_GAP, S_RUN, S_PULSE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHANNELS-1:0] rst_out_q, rst_out_d;
  logic                ready_q, ready_d;

  // Deassertion synchroniser: a zero walks through the chain once rst is low.
  logic [STAGES-1:0] chain_q, chain_d;
  logic              rst_c;

  assign chain_d = {chain_q[STAGES-2:0], 1'b0};
  assign rst_c   = chain_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '1;
    else     chain_q <= chain_d;
  end

  logic waiting;

`ifdef RESET_SEQ_ACK_EN
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [CHANNELS-1:0] ack_prev;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                ackd_q, ackd_d;
  logic                ack_err_q, ack_err_d;

  // Channel 0 has no predecessor, so its gate is always open.
  assign ack_prev[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < CHANNELS; gi++) begin : g_ack_prev
      assign ack_prev[gi] = ack[gi-1];
    end
  endgenerate

  assign waiting = !ackd_q && !ack_prev[idx_q];
  assign ack_err = ack_err_q;
`else
  assign waiting = 1'b0;
`endif

  logic go_pulse;
  assign go_pulse = soft_rst && ((state_q == S_GAP) || (state_q == S_RUN));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
`ifdef RESET_SEQ_ACK_EN
    tcnt_d    = tcnt_q;
    ackd_d    = ackd_q;
    ack_err_d = ack_err_q;
`endif
    if (go_pulse) begin
      state_d   = S_PULSE;
      rst_out_d = '1;
      ready_d   = 1'b0;
      cnt_d     = '0;
`ifdef RESET_SEQ_ACK_EN
      tcnt_d    = '0;
      ackd_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (!rst_c) begin
            state_d = S_GAP;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        S_GAP: begin
          if (waiting) begin
`ifdef RESET_SEQ_ACK_EN
            // A missing ack is flagged but never stalls the sequence for good.
            tcnt_d = tcnt_q + TO_W'(1);
            if (tcnt_q == TO_LAST) begin
              ack_err_d = 1'b1;
              ackd_d    = 1'b1;
              tcnt_d    = '0;
            end
`endif
          end else begin
`ifdef RESET_SEQ_ACK_EN
            ackd_d = 1'b1;
`endif
            if (cnt_q == GAP_LAST) begin
              rst_out_d[idx_q] = 1'b0;
              cnt_d            = '0;
`ifdef RESET_SEQ_ACK_EN
              ackd_d = 1'b0;
              tcnt_d = '0;
`endif
              if (idx_q == IDX_LAST) begin
                state_d = S_RUN;
                ready_d = 1'b1;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        S_PULSE: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          // The minimum hold is measured from the fall of soft_rst.
          if (soft_rst) begin
            cnt_d = '0;
          end else if (cnt_q == PULSE_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
      tcnt_q    <= '0;
      ackd_q    <= 1'b0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
`ifdef RESET_SEQ_ACK_EN
      tcnt_q    <= tcnt_d;
      ackd_q    <= ackd_d;
      ack_err_q <= ack_err_d;
`endif
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;

endmodule
